pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard/control unit for the 5-stage pipeline.
- Produces the 2-bit ctr code for each of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB), plus PC hold and redirect strobes.
- Handles exception flush, memory stall, multi-cycle EX ops, taken branches and load-use hazards.
- Keeps saturating stall/squash statistics counters.
- ctr encoding: 00 normal, 01 squash (load zero/bubble), 10 stall (hold), 11 stall+bubble (hold in latch; not driven by this block).

Parameters:
LONG_LAT, 4, total EX-stage cycles of a multi-cycle op (mul/div); legal range >= 3
REG_W, 5, register-specifier width
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (asserted when 0)
id_rs1  input  REG_W  source reg 1 of instruction in ID
id_rs2  input  REG_W  source reg 2 of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_valid  input  1  EX holds a real (non-bubble) instruction
ex_rd  input  REG_W  destination reg of EX instruction
ex_is_load  input  1  EX instruction is a load
ex_long  input  1  EX instruction is a multi-cycle op
ex_br_taken  input  1  EX branch resolved taken (level while branch in EX)
mem_busy  input  1  MEM stage cannot complete this cycle
flush  input  1  exception flush from MEM
clr_stats  input  1  synchronous clear of statistics counters
ctr_ifid  output  2  ctr for IF/ID latch
ctr_idex  output  2  ctr for ID/EX latch
ctr_exmem  output  2  ctr for EX/MEM latch
ctr_memwb  output  2  ctr for MEM/WB latch
pc_hold  output  1  PC must not advance
pc_redirect  output  1  PC loads branch target
stall_cnt  output  CNT_W  cycles with pc_hold=1, saturating
squash_cnt  output  CNT_W  cycles with pc_redirect=1 or flush=1, saturating

Behaviour:
- Outputs (ifid, idex, exmem, memwb) are combinational from state and inputs, evaluated by the strict priority list below. First match wins.
  1. flush: 01,01,01,00; pc_hold=0; pc_redirect=0. FSM -> IDLE next edge. Redirect target is supplied externally.
  2. mem_busy: 10,10,10,01; pc_hold=1. Bubble enters WB; the MEM instruction is not retired twice.
  3. long_stall (defined below): 10,10,01,00; pc_hold=1.
  4. ex_valid & ex_br_taken: 01,01,00,00; pc_redirect=1; pc_hold=0.
  5. load-use: 10,01,00,00; pc_hold=1.
     - Condition: ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  6. Otherwise: 00,00,00,00; pc_hold=0; pc_redirect=0.
- Long-op FSM, states IDLE/BUSY/DONE, counter width clog2(LONG_LAT):
  - IDLE: start = ex_valid & ex_long & !mem_busy & !flush.
    - start gives long_stall=1 this cycle; next state BUSY, cnt <= LONG_LAT-3.
    - start is deferred while mem_busy; no stall is charged to the long op in those cycles.
  - BUSY: long_stall=1. cnt decrements every cycle, including during mem_busy. When cnt==0, next state DONE.
  - DONE: long_stall=0. Op leaves EX at this edge unless mem_busy. Next state IDLE if !mem_busy, else stay DONE.
  - Stall cycles charged to a long op with no mem_busy = LONG_LAT-1, so the op occupies EX for exactly LONG_LAT cycles.
  - ex_long is ignored in BUSY/DONE.
  - flush in any state -> IDLE next edge.
- Statistics counters:
  - stall_cnt increments when pc_hold=1. squash_cnt increments when flush | pc_redirect.
  - Both saturate at 2^CNT_W-1.
  - clr_stats zeroes both next edge and overrides any increment that cycle.
- Reset (rst=0, async):
  - FSM IDLE, cnt=0, stall_cnt=0, squash_cnt=0.
  - While rst=0, outputs are forced: all ctr=01, pc_hold=1, pc_redirect=0.
  - Reset mid long-op aborts it. First cycle after release is normal priority evaluation.
- Load with ex_rd==0: no hazard. A bubble in EX (ex_valid=0) never causes branch, load-use or long-op action.

Test Plan:
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> exactly 1 cycle of ifid=10, idex=01, pc_hold=1. Same with ex_rd=0 -> all 00.
- Branch: ex_valid=1, ex_br_taken=1 one cycle -> ifid=01, idex=01, pc_redirect=1; squash_cnt 0->1.
- Long op LONG_LAT=4: ex_long held from cycle 0 -> long_stall pattern (10,10,01,00) in cycles 0-2, all 00 in cycle 3 (DONE), FSM IDLE in cycle 4; stall_cnt=3.
- Long op with mem_busy asserted cycle 1-5, LONG_LAT=4 -> mem pattern (10,10,10,01) cycles 1-5; DONE held until mem_busy drops; FSM returns to IDLE cycle 7; no extra stall after mem_busy release.
- Priority: flush=1 together with mem_busy=1, ex_br_taken=1 and FSM BUSY -> 01,01,01,00, pc_redirect=0; FSM IDLE next cycle.
- Reset/stats: drive rst=0 asynchronously mid-BUSY -> all ctr=01 immediately, counters 0. Saturation check with CNT_W=4: 20 stall cycles -> stall_cnt=15. clr_stats during stall -> 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for the 5-stage pipeline: per-latch ctr codes, PC hold/redirect,
// multi-cycle EX op sequencing and saturating stall/squash statistics.
module pipe_hazard_ctrl #(
  parameter int LONG_LAT = 4,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_long,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  input  logic             flush,
  input  logic             clr_stats,
  output logic [1:0]       ctr_ifid,
  output logic [1:0]       ctr_idex,
  output logic [1:0]       ctr_exmem,
  output logic [1:0]       ctr_memwb,
  output logic             pc_hold,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam int CW = $clog2(LONG_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic           start_s;
  logic           long_stall_s;
  logic           branch_s;
  logic           load_use_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // A bubble in EX never triggers any hazard action.
  assign start_s      = (state_r == IDLE) & ex_valid & ex_long & ~mem_busy & ~flush;
  assign long_stall_s = start_s | (state_r == BUSY);
  assign branch_s     = ex_valid & ex_br_taken;
  assign load_use_s   = ex_valid & ex_is_load & (ex_rd != {REG_W{1'b0}}) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Long-op state and countdown register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Long-op next-state logic; BUSY counts down even while MEM is stalled.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flush) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = CW'(LONG_LAT - 3);
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            cnt_nxt_s = cnt_r - CW'(1);
          end
        end
        DONE: begin
          if (!mem_busy) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Priority-ordered latch control; reset forces every latch to squash.
  always_comb begin
    ctr_ifid    = 2'b00;
    ctr_idex    = 2'b00;
    ctr_exmem   = 2'b00;
    ctr_memwb   = 2'b00;
    pc_hold     = 1'b0;
    pc_redirect = 1'b0;
    if (!rst) begin
      ctr_ifid  = 2'b01;
      ctr_idex  = 2'b01;
      ctr_exmem = 2'b01;
      ctr_memwb = 2'b01;
      pc_hold   = 1'b1;
    end else if (flush) begin
      ctr_ifid  = 2'b01;
      ctr_idex  = 2'b01;
      ctr_exmem = 2'b01;
    end else if (mem_busy) begin
      ctr_ifid  = 2'b10;
      ctr_idex  = 2'b10;
      ctr_exmem = 2'b10;
      ctr_memwb = 2'b01;
      pc_hold   = 1'b1;
    end else if (long_stall_s) begin
      ctr_ifid  = 2'b10;
      ctr_idex  = 2'b10;
      ctr_exmem = 2'b01;
      pc_hold   = 1'b1;
    end else if (branch_s) begin
      ctr_ifid    = 2'b01;
      ctr_idex    = 2'b01;
      pc_redirect = 1'b1;
    end else if (load_use_s) begin
      ctr_ifid = 2'b10;
      ctr_idex = 2'b01;
      pc_hold  = 1'b1;
    end else begin
      ctr_ifid = 2'b00;
    end
  end

  // Saturating statistics; clr_stats wins over any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= {CNT_W{1'b0}};
      squash_cnt <= {CNT_W{1'b0}};
    end else if (clr_stats) begin
      stall_cnt  <= {CNT_W{1'b0}};
      squash_cnt <= {CNT_W{1'b0}};
    end else begin
      if (pc_hold) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush | pc_redirect) begin
        squash_cnt <= sat_inc(squash_cnt);
      end else begin
        squash_cnt <= squash_cnt;
      end
    end
  end

endmodule
